// File: rtl/gcd_host_seq_if.sv
// Purpose: bundles the host request/response handshakes and the GCD engine bus.
// Latency: none, wires only.
// Backpressure: req_ready/rsp_ready carry valid-ready flow control in each direction.
// Ports (modport slave = sequencer side):
//   req_valid/req_ready/req_a/req_b   host operand pair in
//   rsp_valid/rsp_ready/rsp_gcd/rsp_timeout  result out
//   gcd_start/gcd_data out, gcd_done/gcd_result in   engine side
interface gcd_host_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_gcd;
  logic       rsp_timeout;
  logic       gcd_start;
  logic [7:0] gcd_data;
  logic       gcd_done;
  logic [7:0] gcd_result;

  // Sequencer side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, gcd_done, gcd_result,
    output req_ready, rsp_valid, rsp_gcd, rsp_timeout, gcd_start, gcd_data
  );

  // Environment side: host plus GCD engine.
  modport master (
    output req_valid, req_a, req_b, rsp_ready, gcd_done, gcd_result,
    input  req_ready, rsp_valid, rsp_gcd, rsp_timeout, gcd_start, gcd_data
  );
endinterface

// File: rtl/gcd_host_seq.sv
// Purpose: sequences one host operand pair through a GCD engine and returns the result.
// Latency: zero operand -> result 1 cycle after accept; otherwise 3 load cycles + WAIT + 1.
// Backpressure: accepts only in IDLE; result held in RESP until rsp_ready.
// Ports: clk, rst (sync, active-high); bus (gcd_host_seq_if.slave) carries the
//   request handshake, response handshake and the engine start/data/done/result.
module gcd_host_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic           clk,
  input logic           rst,
  gcd_host_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    WAIT   = 3'd4,
    RESP   = 3'd5
  } state_t;

  // Counter value seen in the last WAIT cycle before giving up.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rsp_gcd_q, rsp_gcd_d;
  logic       rsp_timeout_q, rsp_timeout_d;

  logic       req_hs;

  assign req_hs = bus.req_valid && (state_q == IDLE);

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    cnt_d         = cnt_q;
    rsp_gcd_d     = rsp_gcd_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (req_hs) begin
          a_d = bus.req_a;
          b_d = bus.req_b;
          if ((bus.req_a == 8'd0) || (bus.req_b == 8'd0)) begin
            // gcd(x,0)=x and gcd(0,0)=0, so the OR is the answer; skip the engine.
            rsp_gcd_d     = bus.req_a | bus.req_b;
            rsp_timeout_d = 1'b0;
            state_d       = RESP;
          end else begin
            state_d = START;
          end
        end
      end
      START:  state_d = LOAD_A;
      LOAD_A: state_d = LOAD_B;
      LOAD_B: begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion is checked first so it wins over a coincident timeout.
        if (bus.gcd_done) begin
          rsp_gcd_d     = bus.gcd_result;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_gcd_d     = 8'd0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      a_q           <= 8'd0;
      b_q           <= 8'd0;
      cnt_q         <= 8'd0;
      rsp_gcd_q     <= 8'd0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      cnt_q         <= cnt_d;
      rsp_gcd_q     <= rsp_gcd_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Shared operand bus: A during START and LOAD_A, B during LOAD_B, otherwise idle at 0.
  always_comb begin
    bus.gcd_data = 8'd0;
    case (state_q)
      START, LOAD_A: bus.gcd_data = a_q;
      LOAD_B:        bus.gcd_data = b_q;
      default:       bus.gcd_data = 8'd0;
    endcase
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.gcd_start   = (state_q == START);
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_gcd     = rsp_gcd_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_gcd_host_seq.sv
// Purpose: randomized self-checking bench for gcd_host_seq against a cycle-timeline model.
// Latency: expected timing is derived from the operand values, engine delay and host stall.
// Backpressure: the host stalls responses by a chosen number of cycles per transaction.
module tb_gcd_host_seq;
  localparam int TMO = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  gcd_host_seq_if bus ();

  gcd_host_seq #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_gcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},   bus.req_ready,   1);
    check({tag, "_rsp_valid"},   bus.rsp_valid,   0);
    check({tag, "_rsp_gcd"},     bus.rsp_gcd,     0);
    check({tag, "_rsp_timeout"}, bus.rsp_timeout, 0);
    check({tag, "_gcd_start"},   bus.gcd_start,   0);
    check({tag, "_gcd_data"},    bus.gcd_data,    0);
  endtask

  // One transaction, entered and left at a negedge with the DUT idle.
  // done_dly: WAIT cycle index (0-based) in which the engine reports done;
  // anything >= TMO means the engine never answers. rdy_dly: host stall cycles.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                         input int done_dly, input int rdy_dly);
    int   g;
    int   exp_g;
    int   exp_to;
    bit   zero;
    g    = ref_gcd(a, b);
    zero = (a == 8'd0) || (b == 8'd0);
    if (zero) begin
      exp_g  = a | b;
      exp_to = 0;
    end else if (done_dly < TMO) begin
      exp_g  = g;
      exp_to = 0;
    end else begin
      exp_g  = 0;
      exp_to = 1;
    end

    check("accept_req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    @(negedge clk);
    // Operands must already be captured; scramble the request inputs.
    bus.req_valid = 1'($urandom_range(0, 1));
    bus.req_a     = 8'($urandom);
    bus.req_b     = 8'($urandom);

    if (!zero) begin
      check("start_pulse", bus.gcd_start, 1);
      check("start_data",  bus.gcd_data,  a);
      check("start_rsp_valid", bus.rsp_valid, 0);
      check("start_req_ready", bus.req_ready, 0);
      bus.gcd_done   = 1'($urandom_range(0, 1));
      bus.gcd_result = 8'($urandom);
      @(negedge clk);
      check("loada_start", bus.gcd_start, 0);
      check("loada_data",  bus.gcd_data,  a);
      bus.gcd_done   = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("loadb_start", bus.gcd_start, 0);
      check("loadb_data",  bus.gcd_data,  b);
      bus.gcd_done   = 1'($urandom_range(0, 1));
      @(negedge clk);
      for (int k = 0; k < TMO; k++) begin
        check("wait_start",     bus.gcd_start, 0);
        check("wait_data",      bus.gcd_data,  0);
        check("wait_rsp_valid", bus.rsp_valid, 0);
        bus.rsp_ready = 1'($urandom_range(0, 1));
        if (k == done_dly) begin
          bus.gcd_done   = 1'b1;
          bus.gcd_result = 8'(g);
        end else begin
          bus.gcd_done   = 1'b0;
          bus.gcd_result = 8'($urandom);
        end
        @(negedge clk);
        if (k == done_dly) break;
      end
    end

    for (int r = 0; r <= rdy_dly; r++) begin
      check("resp_valid",     bus.rsp_valid,   1);
      check("resp_gcd",       bus.rsp_gcd,     exp_g);
      check("resp_timeout",   bus.rsp_timeout, exp_to);
      check("resp_req_ready", bus.req_ready,   0);
      check("resp_start",     bus.gcd_start,   0);
      check("resp_data",      bus.gcd_data,    0);
      bus.rsp_ready  = (r == rdy_dly);
      bus.req_valid  = 1'($urandom_range(0, 1));
      bus.req_a      = 8'($urandom);
      bus.req_b      = 8'($urandom);
      bus.gcd_done   = 1'($urandom_range(0, 1));
      bus.gcd_result = 8'($urandom);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    bus.gcd_done  = 1'b0;
    check("post_rsp_valid", bus.rsp_valid, 0);
    check("post_req_ready", bus.req_ready, 1);
    check("post_start",     bus.gcd_start, 0);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_a      = 8'd0;
    bus.req_b      = 8'd0;
    bus.rsp_ready  = 1'b0;
    bus.gcd_done   = 1'b0;
    bus.gcd_result = 8'd0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_txn(8'd91, 8'd234, 10, 0);
    run_txn(8'd0,  8'd45,  0,  0);
    run_txn(8'd0,  8'd0,   0,  0);
    run_txn(8'd45, 8'd0,   0,  1);
    run_txn(8'd12, 8'd18,  1000, 1);
    run_txn(8'd12, 8'd18,  TMO - 1, 0);
    run_txn(8'd12, 8'd18,  TMO - 2, 0);
    run_txn(8'd91, 8'd234, 10, 5);

    // Reset in WAIT, with a coincident gcd_done and request.
    bus.req_valid = 1'b1;
    bus.req_a     = 8'd100;
    bus.req_b     = 8'd75;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst            = 1'b1;
    bus.gcd_done   = 1'b1;
    bus.gcd_result = 8'd77;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    check("rst_vs_hs_start", bus.gcd_start, 0);
    check("rst_vs_hs_ready", bus.req_ready, 1);
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("stale_done_valid", bus.rsp_valid, 0);
    check("stale_done_ready", bus.req_ready, 1);
    bus.gcd_done = 1'b0;
    run_txn(8'd48, 8'd36, 7, 0);

    // Randomized transactions.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      int         dly;
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 5) == 0) a = 8'd0;
      if ($urandom_range(0, 5) == 0) b = 8'd0;
      dly = ($urandom_range(0, 9) == 0) ? 400 : int'($urandom_range(0, 20));
      run_txn(a, b, dly, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/gcd_host_seq.md
GCD_HOST_SEQ -- requirements
Module: gcd_host_seq

Interface
REQ-001 Parameter: TIMEOUT, default 255, max WAIT-state cycles before abort (1..255).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  host operand pair valid.
REQ-005 req_ready  output  1  block can accept an operand pair.
REQ-006 req_a  input  8  operand A.
REQ-007 req_b  input  8  operand B.
REQ-008 rsp_valid  output  1  result valid.
REQ-009 rsp_ready  input  1  host accepts result.
REQ-010 rsp_gcd  output  8  result value.
REQ-011 rsp_timeout  output  1  result aborted by timeout, qualified by rsp_valid.
REQ-012 gcd_start  output  1  start pulse to GCD engine.
REQ-013 gcd_data  output  8  shared operand bus to GCD engine.
REQ-014 gcd_done  input  1  engine completion flag.
REQ-015 gcd_result  input  8  engine result, valid while gcd_done=1.

Function
REQ-016 FSM states SHALL be IDLE, START, LOAD_A, LOAD_B, WAIT, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready at a rising edge.
REQ-018 On handshake, req_a/req_b SHALL be registered; later req_* changes have no effect.
REQ-019 Handshake with both operands nonzero: next state START.
REQ-020 Handshake with either operand zero: next state RESP, rsp_gcd = req_a | req_b, rsp_timeout=0, engine not engaged (gcd(0,0)=0).
REQ-021 START: gcd_start=1, gcd_data=A; unconditionally to LOAD_A.
REQ-022 LOAD_A: gcd_start=0, gcd_data=A; unconditionally to LOAD_B.
REQ-023 LOAD_B: gcd_data=B; unconditionally to WAIT, wait counter cleared to 0.
REQ-024 gcd_start SHALL be 1 for exactly one cycle per engine transaction, in START only.
REQ-025 gcd_data SHALL be 0 in IDLE, WAIT, RESP.
REQ-026 WAIT: counter increments by 1 each cycle gcd_done=0; 8-bit, never wraps.
REQ-027 WAIT with gcd_done=1: rsp_gcd <= gcd_result, rsp_timeout <= 0, next RESP.
REQ-028 WAIT with gcd_done=0 and counter = TIMEOUT-1: rsp_gcd <= 0, rsp_timeout <= 1, next RESP.
REQ-029 gcd_done=1 on the same cycle as the timeout condition: gcd_done SHALL win (REQ-027).
REQ-030 gcd_done outside WAIT SHALL be ignored.
REQ-031 RESP: rsp_valid=1; rsp_gcd/rsp_timeout held stable until rsp_valid & rsp_ready.
REQ-032 RESP with rsp_ready=1: next IDLE; rsp_valid=0 from next cycle.
REQ-033 No request accepted during RESP; earliest next handshake is the first IDLE cycle.
REQ-034 Latency, nonzero operands: handshake at edge T, gcd_start high in cycle T+1, B on bus in cycle T+3, rsp_valid asserted cycle after gcd_done sampled in WAIT.
REQ-035 Zero-operand latency: rsp_valid asserted in cycle T+1.

Reset
REQ-036 rst=1 at a rising edge SHALL force IDLE from any state, including mid-transaction.
REQ-037 Reset values: req_ready=1 (first cycle after reset), rsp_valid=0, rsp_gcd=0, rsp_timeout=0, gcd_start=0, gcd_data=0, counter=0, operand registers=0.
REQ-038 rst SHALL take priority over every handshake and gcd_done sampled on the same edge.

Verification
REQ-039 A=91, B=234, engine model done after 10 WAIT cycles with result 13 -> gcd_start single pulse, gcd_data 91,91,234, rsp_gcd=13, rsp_timeout=0.
REQ-040 A=0, B=45 -> rsp_valid cycle T+1, rsp_gcd=45, gcd_start never asserted; A=0,B=0 -> rsp_gcd=0.
REQ-041 A=12, B=18, gcd_done never asserted, TIMEOUT=255 -> rsp_valid after 255 WAIT cycles, rsp_gcd=0, rsp_timeout=1.
REQ-042 gcd_done=1 with gcd_result=6 on the exact timeout cycle -> rsp_gcd=6, rsp_timeout=0.
REQ-043 Result 13 held with rsp_ready=0 for 5 cycles -> rsp_valid/rsp_gcd stable, req_ready=0, req_valid ignored; rsp_ready=1 -> IDLE next cycle.
REQ-044 rst=1 during WAIT then new request 48/36 -> all outputs at reset values, second transaction returns 12, stale gcd_done ignored.
